imuldiv_div_resp_sel: RTL and testbench

Writeback-side stage directly downstream of the iterative integer divider. It records a destination tag and a quotient/remainder select for every accepted divide request in an in-order tag FIFO. It then consumes the divider's 64-bit {remainder, quotient} response and emits one registered 32-bit writeback message per response. It also gates request acceptance so that the number of outstanding requests never exceeds the FIFO depth.

---
 rtl/imuldiv_div_resp_sel_pkg.sv | 42 ++++
 rtl/imuldiv_div_tag_fifo.sv | 71 +++++++
 rtl/imuldiv_div_resp_sel.sv | 115 +++++++++++
 tb/tb_imuldiv_div_resp_sel.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_div_resp_sel_pkg.sv
// ============================================================================
// Module   : imuldiv_DivRespSelPkg
// Brief    : Shared constants and helpers for the divider response selector.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package imuldiv_DivRespSelPkg;

    localparam logic SEL_QUOT = 1'b0;
    localparam logic SEL_REM  = 1'b1;

    localparam int RESULT_W = 64;
    localparam int DATA_W   = 32;
    localparam int QUOT_LSB = 0;
    localparam int QUOT_MSB = 31;
    localparam int REM_LSB  = 32;
    localparam int REM_MSB  = 63;

    // FIFO entries are packed as {sel, tag}: sel sits just above the tag bits.
    function automatic int entry_w(input int tag_w);
        return tag_w + 1;
    endfunction

    function automatic int entry_sel_idx(input int tag_w);
        return tag_w;
    endfunction

    function automatic logic [DATA_W-1:0] sel_result(input logic sel,
                                                     input logic [RESULT_W-1:0] result);
        logic [DATA_W-1:0] data;
        data = result[QUOT_MSB:QUOT_LSB];
        case (sel)
            SEL_QUOT: data = result[QUOT_MSB:QUOT_LSB];
            SEL_REM:  data = result[REM_MSB:REM_LSB];
        endcase
        return data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imuldiv_div_tag_fifo.sv
// ============================================================================
// Module   : imuldiv_div_tag_fifo
// Brief    : In-order tag FIFO; pushes while full are dropped, no bypass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imuldiv_div_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    // DEPTH must be a power of two >= 2 so the pointers wrap for free.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/imuldiv_div_resp_sel.sv
// ============================================================================
// Module   : imuldiv_div_resp_sel
// Brief    : Selects quotient/remainder from divider responses and registers
//            one tagged writeback per response; gates request issue.
//            Optional macro IMULDIV_DIV_RESP_SEL_COUNT_EN adds resp_count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imuldiv_div_resp_sel
    import imuldiv_DivRespSelPkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_fire,
    input  logic             req_sel,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_gate,
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    output logic [31:0]      wb_msg_data,
    output logic [TAG_W-1:0] wb_msg_tag,
    output logic             wb_val,
    input  logic             wb_rdy
`ifdef IMULDIV_DIV_RESP_SEL_COUNT_EN
    ,
    output logic [31:0]      resp_count
`endif
);

    localparam int ENTRY_W = entry_w(TAG_W);
    localparam int SEL_IDX = entry_sel_idx(TAG_W);

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               out_free;
    logic               resp_fire;

    logic               wb_val_q,  wb_val_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic [TAG_W-1:0]   wb_tag_q,  wb_tag_d;

    imuldiv_div_tag_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (resp_fire),
        .din   ({req_sel, req_tag}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign req_gate    = ~fifo_full;
    assign out_free    = ~wb_val_q | wb_rdy;
    assign divresp_rdy = ~fifo_empty & out_free;
    assign resp_fire   = divresp_val & divresp_rdy;

    always_comb begin
        wb_val_d  = wb_val_q;
        wb_data_d = wb_data_q;
        wb_tag_d  = wb_tag_q;
        if (resp_fire) begin
            wb_val_d  = 1'b1;
            wb_data_d = sel_result(fifo_head[SEL_IDX], divresp_msg_result);
            wb_tag_d  = fifo_head[TAG_W-1:0];
        end else if (wb_rdy) begin
            // Drained with nothing to replace it; payload deliberately held.
            wb_val_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_val_q  <= 1'b0;
            wb_data_q <= '0;
            wb_tag_q  <= '0;
        end else begin
            wb_val_q  <= wb_val_d;
            wb_data_q <= wb_data_d;
            wb_tag_q  <= wb_tag_d;
        end
    end

    assign wb_val      = wb_val_q;
    assign wb_msg_data = wb_data_q;
    assign wb_msg_tag  = wb_tag_q;

`ifdef IMULDIV_DIV_RESP_SEL_COUNT_EN
    logic [31:0] resp_count_q, resp_count_d;

    assign resp_count_d = (wb_val_q & wb_rdy) ? resp_count_q + 32'd1 : resp_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_count_q <= '0;
        end else begin
            resp_count_q <= resp_count_d;
        end
    end

    assign resp_count = resp_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imuldiv_div_resp_sel.sv
// ============================================================================
// Module   : tb_imuldiv_div_resp_sel
// Brief    : Directed self-checking bench for imuldiv_div_resp_sel (DEPTH=2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imuldiv_div_resp_sel;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_fire;
    logic             req_sel;
    logic [TAG_W-1:0] req_tag;
    logic             req_gate;
    logic [63:0]      divresp_msg_result;
    logic             divresp_val;
    logic             divresp_rdy;
    logic [31:0]      wb_msg_data;
    logic [TAG_W-1:0] wb_msg_tag;
    logic             wb_val;
    logic             wb_rdy;
`ifdef IMULDIV_DIV_RESP_SEL_COUNT_EN
    logic [31:0]      resp_count;
`endif

    int passed = 0;
    int total  = 0;

    imuldiv_div_resp_sel #(
        .DEPTH (2),
        .TAG_W (TAG_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_fire           (req_fire),
        .req_sel            (req_sel),
        .req_tag            (req_tag),
        .req_gate           (req_gate),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .wb_msg_data        (wb_msg_data),
        .wb_msg_tag         (wb_msg_tag),
        .wb_val             (wb_val),
        .wb_rdy             (wb_rdy)
`ifdef IMULDIV_DIV_RESP_SEL_COUNT_EN
        ,
        .resp_count         (resp_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [TAG_W-1:0] tag);
        req_fire = 1'b1;
        req_sel  = sel;
        req_tag  = tag;
        step();
        req_fire = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++; if (wb_val !== 1'b0) $display("FAIL reset_wb_val: got %b expected 0", wb_val); else passed++;
        total++; if (wb_msg_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", wb_msg_data); else passed++;
        total++; if (wb_msg_tag !== 5'd0) $display("FAIL reset_tag: got %0d expected 0", wb_msg_tag); else passed++;
        total++; if (req_gate !== 1'b1) $display("FAIL reset_gate: got %b expected 1", req_gate); else passed++;
        total++; if (divresp_rdy !== 1'b0) $display("FAIL reset_rdy: got %b expected 0", divresp_rdy); else passed++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_quotient();
        push(1'b0, 5'd3);
        divresp_val        = 1'b1;
        divresp_msg_result = 64'h00000000_0000000d;
        #1;
        total++; if (divresp_rdy !== 1'b1) $display("FAIL quot_rdy: got %b expected 1", divresp_rdy); else passed++;
        total++; if (wb_val !== 1'b0) $display("FAIL quot_pre_val: got %b expected 0", wb_val); else passed++;
        step();
        divresp_val = 1'b0;
        total++; if (wb_val !== 1'b1) $display("FAIL quot_val: got %b expected 1", wb_val); else passed++;
        total++; if (wb_msg_data !== 32'h0000000d) $display("FAIL quot_data: got %h expected 0000000d", wb_msg_data); else passed++;
        total++; if (wb_msg_tag !== 5'd3) $display("FAIL quot_tag: got %0d expected 3", wb_msg_tag); else passed++;
        step();
        total++; if (wb_val !== 1'b0) $display("FAIL quot_drain: got %b expected 0", wb_val); else passed++;
        total++; if (wb_msg_data !== 32'h0000000d) $display("FAIL quot_hold: got %h expected 0000000d", wb_msg_data); else passed++;
    endtask

    task automatic test_remainder();
        push(1'b1, 5'd7);
        divresp_val        = 1'b1;
        divresp_msg_result = 64'h0000002e_0000000a;
        step();
        divresp_val = 1'b0;
        total++; if (wb_val !== 1'b1) $display("FAIL rem_val: got %b expected 1", wb_val); else passed++;
        total++; if (wb_msg_data !== 32'h0000002e) $display("FAIL rem_data: got %h expected 0000002e", wb_msg_data); else passed++;
        total++; if (wb_msg_tag !== 5'd7) $display("FAIL rem_tag: got %0d expected 7", wb_msg_tag); else passed++;
        step();
    endtask

    task automatic test_fill_gate();
        push(1'b0, 5'd1);
        total++; if (req_gate !== 1'b1) $display("FAIL fill_gate1: got %b expected 1", req_gate); else passed++;
        push(1'b1, 5'd2);
        total++; if (req_gate !== 1'b0) $display("FAIL fill_gate2: got %b expected 0", req_gate); else passed++;
        push(1'b0, 5'd9);
        total++; if (req_gate !== 1'b0) $display("FAIL fill_gate3: got %b expected 0", req_gate); else passed++;
        divresp_val        = 1'b1;
        divresp_msg_result = 64'h11111111_22222222;
        #1;
        total++; if (divresp_rdy !== 1'b1) $display("FAIL fill_rdy: got %b expected 1", divresp_rdy); else passed++;
        total++; if (req_gate !== 1'b0) $display("FAIL fill_nobypass: got %b expected 0", req_gate); else passed++;
        step();
        divresp_msg_result = 64'h33333333_44444444;
        total++; if (wb_msg_data !== 32'h22222222) $display("FAIL fill_data1: got %h expected 22222222", wb_msg_data); else passed++;
        total++; if (wb_msg_tag !== 5'd1) $display("FAIL fill_tag1: got %0d expected 1", wb_msg_tag); else passed++;
        total++; if (req_gate !== 1'b1) $display("FAIL fill_gate_pop: got %b expected 1", req_gate); else passed++;
        step();
        divresp_val = 1'b0;
        total++; if (wb_val !== 1'b1) $display("FAIL fill_val2: got %b expected 1", wb_val); else passed++;
        total++; if (wb_msg_data !== 32'h33333333) $display("FAIL fill_data2: got %h expected 33333333", wb_msg_data); else passed++;
        total++; if (wb_msg_tag !== 5'd2) $display("FAIL fill_tag2: got %0d expected 2", wb_msg_tag); else passed++;
        total++; if (divresp_rdy !== 1'b0) $display("FAIL fill_dropped_push: got %b expected 0", divresp_rdy); else passed++;
        step();
        total++; if (wb_val !== 1'b0) $display("FAIL fill_drain: got %b expected 0", wb_val); else passed++;
    endtask

    task automatic test_wb_stall();
        wb_rdy = 1'b0;
        push(1'b0, 5'd4);
        push(1'b1, 5'd5);
        divresp_val        = 1'b1;
        divresp_msg_result = 64'h00000055_00000066;
        step();
        divresp_msg_result = 64'h00000077_00000088;
        for (int i = 0; i < 5; i++) begin
            total++; if (divresp_rdy !== 1'b0) $display("FAIL stall_rdy[%0d]: got %b expected 0", i, divresp_rdy); else passed++;
            total++; if ({wb_val, wb_msg_data, wb_msg_tag} !== {1'b1, 32'h00000066, 5'd4})
                $display("FAIL stall_hold[%0d]: got %b/%h/%0d expected 1/00000066/4", i, wb_val, wb_msg_data, wb_msg_tag);
            else passed++;
            step();
        end
        wb_rdy = 1'b1;
        #1;
        total++; if (divresp_rdy !== 1'b1) $display("FAIL stall_release_rdy: got %b expected 1", divresp_rdy); else passed++;
        step();
        divresp_val = 1'b0;
        total++; if (wb_val !== 1'b1) $display("FAIL stall_b2b_val: got %b expected 1", wb_val); else passed++;
        total++; if (wb_msg_data !== 32'h00000077) $display("FAIL stall_data2: got %h expected 00000077", wb_msg_data); else passed++;
        total++; if (wb_msg_tag !== 5'd5) $display("FAIL stall_tag2: got %0d expected 5", wb_msg_tag); else passed++;
        step();
    endtask

    task automatic test_empty();
        divresp_val        = 1'b1;
        divresp_msg_result = 64'h000000aa_000000bb;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (divresp_rdy !== 1'b0) $display("FAIL empty_rdy[%0d]: got %b expected 0", i, divresp_rdy); else passed++;
            step();
        end
        req_fire = 1'b1;
        req_sel  = 1'b1;
        req_tag  = 5'd6;
        #1;
        total++; if (divresp_rdy !== 1'b0) $display("FAIL empty_push_cycle_rdy: got %b expected 0", divresp_rdy); else passed++;
        step();
        req_fire = 1'b0;
        #1;
        total++; if (divresp_rdy !== 1'b1) $display("FAIL empty_after_push_rdy: got %b expected 1", divresp_rdy); else passed++;
        step();
        divresp_val = 1'b0;
        total++; if (wb_msg_data !== 32'h000000aa) $display("FAIL empty_data: got %h expected 000000aa", wb_msg_data); else passed++;
        total++; if (wb_msg_tag !== 5'd6) $display("FAIL empty_tag: got %0d expected 6", wb_msg_tag); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        push(1'b0, 5'd8);
        push(1'b0, 5'd9);
        wb_rdy             = 1'b0;
        divresp_val        = 1'b1;
        divresp_msg_result = 64'h00000000_00000123;
        step();
        divresp_val = 1'b0;
        total++; if (wb_val !== 1'b1) $display("FAIL rmid_pre_val: got %b expected 1", wb_val); else passed++;
`ifdef IMULDIV_DIV_RESP_SEL_COUNT_EN
        total++; if (resp_count !== 32'd7) $display("FAIL rmid_pre_count: got %0d expected 7", resp_count); else passed++;
`endif
        reset  = 1'b0;
        wb_rdy = 1'b1;
        step();
        total++; if (wb_val !== 1'b0) $display("FAIL rmid_val: got %b expected 0", wb_val); else passed++;
        total++; if (req_gate !== 1'b1) $display("FAIL rmid_gate: got %b expected 1", req_gate); else passed++;
        total++; if (divresp_rdy !== 1'b0) $display("FAIL rmid_rdy: got %b expected 0", divresp_rdy); else passed++;
        total++; if (wb_msg_data !== 32'h0) $display("FAIL rmid_data: got %h expected 00000000", wb_msg_data); else passed++;
`ifdef IMULDIV_DIV_RESP_SEL_COUNT_EN
        total++; if (resp_count !== 32'd0) $display("FAIL rmid_count: got %0d expected 0", resp_count); else passed++;
`endif
        reset = 1'b1;
        step();
    endtask

    initial begin
        reset              = 1'b0;
        req_fire           = 1'b0;
        req_sel            = 1'b0;
        req_tag            = '0;
        divresp_msg_result = '0;
        divresp_val        = 1'b0;
        wb_rdy             = 1'b1;
        test_reset();
        test_quotient();
        test_remainder();
        test_fill_gate();
        test_wb_stall();
        test_empty();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
